// File: rtl/output_packet_streamer_pkg.sv
// Shared definitions for the output packet streamer.
//   - header geometry and BRAM geometry
//   - FSM state encoding
//   - header magic words used by the output manager
//   - count clamp helper
package output_packet_streamer_pkg;

  localparam int unsigned HdrLen    = 6;
  localparam int unsigned HdrIdxW   = 3;
  localparam int unsigned BramDepth = 512;
  localparam int unsigned BramAddrW = 9;
  localparam int unsigned BramSelW  = 3;
  // Words per BRAM after clamping: 0..512.
  localparam int unsigned CountW    = 10;
  // Data beats per packet: up to 8 * 512 = 4096.
  localparam int unsigned BeatsW    = 13;

  localparam logic [15:0] MagicNotify = 16'hC0DE;
  localparam logic [15:0] MagicData   = 16'hDA7A;

  typedef enum logic [1:0] {
    StIdle,
    StHdr,
    StData,
    StDone
  } state_e;

  // Requests larger than one BRAM read the whole BRAM.
  function automatic logic [CountW-1:0] clamp_count(input logic [15:0] c);
    if (c > 16'(BramDepth)) begin
      return CountW'(BramDepth);
    end
    return c[CountW-1:0];
  endfunction

endpackage

// File: rtl/stream_prefetch_fifo.sv
// Small synchronous FIFO that holds prefetched BRAM words ahead of the stream.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset (empties the FIFO)
//   push, push_data  write one word (ignored when full)
//   pop              drop the head word (ignored when empty)
//   head             current head word
//   count            number of stored words, 0..DEPTH
//   empty            count == 0
module stream_prefetch_fifo #(
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  output logic [DW-1:0]            head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign empty   = (count_q == '0);
  assign do_push = push && (count_q != (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Power-of-two depth: pointers wrap naturally.
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/output_packet_streamer.sv
// Streams one output packet over AXI-Stream: a 6-word header followed by the
// words of a BRAM range, prefetched through a 1-cycle-latency read port.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   header_word_0..5, send_header  header contents, latched on send_header in idle
//   trigger_read                   start a packet (ignored and flagged while busy)
//   rd_bram_start/end, rd_addr_count  inclusive BRAM range and words per BRAM
//   bram_rd_en/sel/addr, bram_rd_data BRAM read port, data one cycle after enable
//   m_axis_*                       AXI-Stream master
//   read_done                      one-cycle pulse after the last beat is accepted
//   busy                           packet in progress
//   trigger_overrun                sticky: trigger_read arrived while not idle
module output_packet_streamer
  import output_packet_streamer_pkg::*;
#(
  parameter int unsigned DW         = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [15:0]          header_word_0,
  input  logic [15:0]          header_word_1,
  input  logic [15:0]          header_word_2,
  input  logic [15:0]          header_word_3,
  input  logic [15:0]          header_word_4,
  input  logic [15:0]          header_word_5,
  input  logic                 send_header,
  input  logic                 trigger_read,
  input  logic [BramSelW-1:0]  rd_bram_start,
  input  logic [BramSelW-1:0]  rd_bram_end,
  input  logic [15:0]          rd_addr_count,
  output logic                 bram_rd_en,
  output logic [BramSelW-1:0]  bram_rd_sel,
  output logic [BramAddrW-1:0] bram_rd_addr,
  input  logic [DW-1:0]        bram_rd_data,
  output logic [DW-1:0]        m_axis_tdata,
  output logic                 m_axis_tvalid,
  output logic                 m_axis_tlast,
  input  logic                 m_axis_tready,
  output logic                 read_done,
  output logic                 busy,
  output logic                 trigger_overrun
);

  localparam int unsigned FifoCntW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned OccW     = FifoCntW + 1;

  state_e               state_q, state_d;
  logic [15:0]          hdr_in [HdrLen];
  logic [15:0]          hdr_q  [HdrLen];
  logic [15:0]          hdr_d  [HdrLen];
  logic [HdrIdxW-1:0]   hdr_idx_q, hdr_idx_d;
  logic [BramSelW-1:0]  end_q, end_d;
  logic [BramSelW-1:0]  cur_sel_q, cur_sel_d;
  logic [BramAddrW-1:0] cur_addr_q, cur_addr_d;
  logic [CountW-1:0]    count_q, count_d;
  logic                 rd_pending_q, rd_pending_d;
  logic                 inflight_q, inflight_d;
  logic [BeatsW-1:0]    beats_left_q, beats_left_d;
  logic                 overrun_q, overrun_d;

  logic [BramSelW-1:0]  eff_end;
  logic [CountW-1:0]    eff_count;
  logic [BramSelW:0]    num_bram;
  logic [BeatsW-1:0]    total_beats;
  logic [FifoCntW-1:0]  fifo_count;
  logic [OccW-1:0]      occupancy;
  logic                 fifo_empty;
  logic [DW-1:0]        fifo_head;
  logic                 fifo_pop;
  logic                 beat;

  assign hdr_in[0] = header_word_0;
  assign hdr_in[1] = header_word_1;
  assign hdr_in[2] = header_word_2;
  assign hdr_in[3] = header_word_3;
  assign hdr_in[4] = header_word_4;
  assign hdr_in[5] = header_word_5;

  // Range normalisation applied at trigger time.
  assign eff_end     = (rd_bram_end < rd_bram_start) ? rd_bram_start : rd_bram_end;
  assign eff_count   = clamp_count(rd_addr_count);
  assign num_bram    = {1'b0, eff_end} - {1'b0, rd_bram_start} + (BramSelW+1)'(1);
  assign total_beats = BeatsW'(num_bram) * BeatsW'(eff_count);

  // Words held plus the read whose data lands next cycle must fit in the FIFO.
  assign occupancy  = OccW'(fifo_count) + OccW'(inflight_q);
  assign bram_rd_en = (state_q == StHdr || state_q == StData) && rd_pending_q &&
                      (occupancy < OccW'(FIFO_DEPTH));
  assign bram_rd_sel  = cur_sel_q;
  assign bram_rd_addr = cur_addr_q;

  assign busy            = (state_q == StHdr) || (state_q == StData);
  assign read_done       = (state_q == StDone);
  assign trigger_overrun = overrun_q;
  assign beat            = m_axis_tvalid && m_axis_tready;

  stream_prefetch_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .push_data (bram_rd_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  // Output mux.
  always_comb begin
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    fifo_pop      = 1'b0;
    unique case (state_q)
      StHdr: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = DW'(hdr_q[hdr_idx_q]);
        m_axis_tlast  = (hdr_idx_q == HdrIdxW'(HdrLen - 1)) && (count_q == '0);
      end
      StData: begin
        m_axis_tvalid = !fifo_empty;
        m_axis_tdata  = fifo_head;
        m_axis_tlast  = !fifo_empty && (beats_left_q == BeatsW'(1));
        fifo_pop      = !fifo_empty && m_axis_tready;
      end
      default: ;
    endcase
  end

  // Next-state: FSM, header latch and address generator.
  always_comb begin
    state_d      = state_q;
    hdr_d        = hdr_q;
    hdr_idx_d    = hdr_idx_q;
    end_d        = end_q;
    cur_sel_d    = cur_sel_q;
    cur_addr_d   = cur_addr_q;
    count_d      = count_q;
    rd_pending_d = rd_pending_q;
    inflight_d   = bram_rd_en;
    beats_left_d = beats_left_q;
    overrun_d    = overrun_q || (trigger_read && state_q != StIdle);

    if (bram_rd_en) begin
      if ({1'b0, cur_addr_q} == count_q - CountW'(1)) begin
        if (cur_sel_q == end_q) begin
          rd_pending_d = 1'b0;
        end else begin
          cur_sel_d  = cur_sel_q + BramSelW'(1);
          cur_addr_d = '0;
        end
      end else begin
        cur_addr_d = cur_addr_q + BramAddrW'(1);
      end
    end

    unique case (state_q)
      StIdle: begin
        if (send_header) hdr_d = hdr_in;
        if (trigger_read) begin
          state_d      = StHdr;
          hdr_idx_d    = '0;
          end_d        = eff_end;
          cur_sel_d    = rd_bram_start;
          cur_addr_d   = '0;
          count_d      = eff_count;
          rd_pending_d = (eff_count != '0);
          beats_left_d = total_beats;
        end
      end
      StHdr: begin
        if (beat) begin
          hdr_idx_d = hdr_idx_q + HdrIdxW'(1);
          if (hdr_idx_q == HdrIdxW'(HdrLen - 1)) begin
            state_d = (count_q == '0) ? StDone : StData;
          end
        end
      end
      StData: begin
        if (beat) begin
          beats_left_d = beats_left_q - BeatsW'(1);
          if (beats_left_q == BeatsW'(1)) state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      for (int i = 0; i < HdrLen; i++) hdr_q[i] <= '0;
      hdr_idx_q    <= '0;
      end_q        <= '0;
      cur_sel_q    <= '0;
      cur_addr_q   <= '0;
      count_q      <= '0;
      rd_pending_q <= 1'b0;
      inflight_q   <= 1'b0;
      beats_left_q <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hdr_q        <= hdr_d;
      hdr_idx_q    <= hdr_idx_d;
      end_q        <= end_d;
      cur_sel_q    <= cur_sel_d;
      cur_addr_q   <= cur_addr_d;
      count_q      <= count_d;
      rd_pending_q <= rd_pending_d;
      inflight_q   <= inflight_d;
      beats_left_q <= beats_left_d;
      overrun_q    <= overrun_d;
    end
  end

endmodule

// File: tb/tb_output_packet_streamer.sv
module tb_output_packet_streamer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] hw [6];
  logic        send_header, trigger_read;
  logic [2:0]  rd_bram_start, rd_bram_end;
  logic [15:0] rd_addr_count;
  logic        bram_rd_en;
  logic [2:0]  bram_rd_sel;
  logic [8:0]  bram_rd_addr;
  logic [15:0] bram_rd_data;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic        read_done, busy, trigger_overrun;

  output_packet_streamer #(
    .DW         (16),
    .FIFO_DEPTH (4)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .header_word_0   (hw[0]),
    .header_word_1   (hw[1]),
    .header_word_2   (hw[2]),
    .header_word_3   (hw[3]),
    .header_word_4   (hw[4]),
    .header_word_5   (hw[5]),
    .send_header     (send_header),
    .trigger_read    (trigger_read),
    .rd_bram_start   (rd_bram_start),
    .rd_bram_end     (rd_bram_end),
    .rd_addr_count   (rd_addr_count),
    .bram_rd_en      (bram_rd_en),
    .bram_rd_sel     (bram_rd_sel),
    .bram_rd_addr    (bram_rd_addr),
    .bram_rd_data    (bram_rd_data),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tlast    (m_axis_tlast),
    .m_axis_tready   (m_axis_tready),
    .read_done       (read_done),
    .busy            (busy),
    .trigger_overrun (trigger_overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_count, rd_count, tlast_count, last_tlast_beat, done_count, done_cyc, trig_cyc;
  logic [15:0] seen [$];
  bit tready_rand = 1'b0;

  // Reference model state.
  logic [15:0] exp_q [$];
  logic [11:0] rq [$];
  logic [15:0] m_hdr [6];
  bit m_active = 1'b0;
  bit m_done = 1'b0;
  bit m_overrun = 1'b0;

  function automatic logic [15:0] bram_word(input logic [2:0] s, input logic [8:0] a);
    return {s, 4'b0000, a} ^ 16'h1234;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Whole packet expectation from the range rules: header, then every word of
  // every BRAM in the range, BRAM by BRAM.
  task automatic model_start(input logic [2:0] s, input logic [2:0] e0, input logic [15:0] c0);
    int e, c;
    e = (e0 < s) ? int'(s) : int'(e0);
    c = (c0 > 16'd512) ? 512 : int'(c0);
    for (int i = 0; i < 6; i++) exp_q.push_back(m_hdr[i]);
    for (int b = int'(s); b <= e; b++) begin
      for (int a = 0; a < c; a++) begin
        exp_q.push_back(bram_word(3'(b), 9'(a)));
        rq.push_back({3'(b), 9'(a)});
      end
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous BRAM with 1-cycle read latency.
  always @(posedge clk) begin
    if (bram_rd_en) bram_rd_data <= bram_word(bram_rd_sel, bram_rd_addr);
  end

  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_axis_tready = tready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    bit last_hs;
    last_hs = 1'b0;
    if (!rst_n) begin
      check("rst_tvalid", m_axis_tvalid, 0);
      check("rst_tdata", m_axis_tdata, 0);
      check("rst_busy", busy, 0);
      check("rst_read_done", read_done, 0);
      check("rst_rd_en", bram_rd_en, 0);
      check("rst_overrun", trigger_overrun, 0);
      exp_q.delete();
      rq.delete();
      m_active = 1'b0;
      m_done = 1'b0;
      m_overrun = 1'b0;
      for (int i = 0; i < 6; i++) m_hdr[i] = '0;
    end else begin
      check("tvalid", m_axis_tvalid, m_active);
      check("busy", busy, m_active);
      check("read_done", read_done, m_done);
      check("overrun", trigger_overrun, m_overrun);
      if (read_done) begin
        done_count++;
        done_cyc = cyc;
      end
      if (bram_rd_en) begin
        rd_count++;
        checks++;
        if (rq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_read: sel %0d addr %0d with no read expected", bram_rd_sel,
                   bram_rd_addr);
        end else begin
          if ({bram_rd_sel, bram_rd_addr} !== rq[0]) begin
            errors++;
            $display("FAIL rd_sel_addr: got %0h expected %0h", {bram_rd_sel, bram_rd_addr}, rq[0]);
          end
          void'(rq.pop_front());
        end
      end
      if (m_axis_tvalid && m_active) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_beat: tdata %0h with no beat expected", m_axis_tdata);
        end else begin
          check("tdata", m_axis_tdata, exp_q[0]);
          check("tlast", m_axis_tlast, exp_q.size() == 1);
          if (m_axis_tready) begin
            hs_count++;
            seen.push_back(m_axis_tdata);
            if (m_axis_tlast) begin
              tlast_count++;
              last_tlast_beat = hs_count;
            end
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) last_hs = 1'b1;
          end
        end
      end
      // Model advance for the next cycle.
      if (trigger_read) begin
        if (!m_active && !m_done) begin
          if (send_header) m_hdr = hw;
          model_start(rd_bram_start, rd_bram_end, rd_addr_count);
          m_active = 1'b1;
        end else begin
          m_overrun = 1'b1;
        end
      end else if (send_header && !m_active && !m_done) begin
        m_hdr = hw;
      end
      if (last_hs) m_active = 1'b0;
      m_done = last_hs;
    end
  end

  task automatic start_pkt(input logic [15:0] h [6], input bit sh, input logic [2:0] s,
                           input logic [2:0] e, input logic [15:0] c);
    @(posedge clk);
    #1;
    hw = h;
    send_header = sh;
    trigger_read = 1'b1;
    rd_bram_start = s;
    rd_bram_end = e;
    rd_addr_count = c;
    hs_count = 0;
    rd_count = 0;
    tlast_count = 0;
    last_tlast_beat = 0;
    seen.delete();
    trig_cyc = cyc;
    @(posedge clk);
    #1;
    trigger_read = 1'b0;
    send_header = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((m_active || m_done) && n < budget) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (m_active || m_done) begin
      errors++;
      $display("FAIL %s_timeout: packet still open after %0d cycles", name, budget);
    end
    check({name, "_leftover_beats"}, exp_q.size(), 0);
    check({name, "_leftover_reads"}, rq.size(), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] h [6];
    int d0, n;
    for (int i = 0; i < 6; i++) hw[i] = '0;
    send_header = 1'b0;
    trigger_read = 1'b0;
    rd_bram_start = '0;
    rd_bram_end = '0;
    rd_addr_count = '0;
    done_count = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("init_tvalid", m_axis_tvalid, 0);
    check("init_busy", busy, 0);
    rst_n = 1'b1;

    // Notification packet.
    h = '{16'hC0DE, 16'h0001, 16'h0002, 16'h0008, 16'h000B, 16'h0200};
    d0 = done_count;
    start_pkt(h, 1'b1, 3'd0, 3'd0, 16'd512);
    wait_idle("notify", 2000);
    check("notify_beats", hs_count, 518);
    check("notify_hdr0", seen[0], 16'hC0DE);
    check("notify_hdr5", seen[5], 16'h0200);
    check("notify_data0", seen[6], 16'h1234);
    check("notify_data511", seen[517], 16'h13CB);
    check("notify_tlast_n", tlast_count, 1);
    check("notify_tlast_at", last_tlast_beat, 518);
    check("notify_reads", rd_count, 512);
    check("notify_done_n", done_count - d0, 1);

    // Full data, tready held high: back-to-back beats.
    h = '{16'hDA7A, 16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0055};
    start_pkt(h, 1'b1, 3'd0, 3'd7, 16'd512);
    wait_idle("full", 6000);
    check("full_beats", hs_count, 4102);
    check("full_reads", rd_count, 4096);
    check("full_latency", done_cyc - trig_cyc, 4103);
    check("full_hdr0", seen[0], 16'hDA7A);
    check("full_bram1_0", seen[518], 16'h3234);
    check("full_last", seen[4101], 16'hF3CB);

    // Same packet with random backpressure, header reused without send_header.
    tready_rand = 1'b1;
    start_pkt(h, 1'b0, 3'd0, 3'd7, 16'd512);
    wait_idle("full_bp", 20000);
    check("full_bp_beats", hs_count, 4102);
    check("full_bp_hdr0", seen[0], 16'hDA7A);
    check("full_bp_tlast_n", tlast_count, 1);
    tready_rand = 1'b0;

    // Header-only packet.
    start_pkt(h, 1'b0, 3'd3, 3'd3, 16'd0);
    wait_idle("count0", 200);
    check("count0_beats", hs_count, 6);
    check("count0_reads", rd_count, 0);
    check("count0_tlast_at", last_tlast_beat, 6);

    // Reversed range collapses to the start BRAM.
    start_pkt(h, 1'b0, 3'd5, 3'd2, 16'd3);
    wait_idle("rev", 200);
    check("rev_beats", hs_count, 9);
    check("rev_reads", rd_count, 3);
    check("rev_data0", seen[6], 16'hB234);

    // Overlong count clamps to a full BRAM.
    start_pkt(h, 1'b0, 3'd4, 3'd4, 16'd700);
    wait_idle("clamp", 2000);
    check("clamp_beats", hs_count, 518);

    // Trigger while busy is ignored and flagged.
    start_pkt(h, 1'b0, 3'd1, 3'd2, 16'd20);
    repeat (10) @(posedge clk);
    #1;
    trigger_read = 1'b1;
    rd_bram_start = 3'd6;
    rd_bram_end = 3'd7;
    rd_addr_count = 16'd5;
    @(posedge clk);
    #1;
    trigger_read = 1'b0;
    wait_idle("overrun", 500);
    check("overrun_beats", hs_count, 46);
    check("overrun_flag", trigger_overrun, 1);

    // Header-only pulse in idle, then random packets under backpressure.
    h = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, 16'hEEEE, 16'hFFFF};
    @(posedge clk);
    #1;
    hw = h;
    send_header = 1'b1;
    @(posedge clk);
    #1;
    send_header = 1'b0;
    start_pkt(h, 1'b0, 3'd0, 3'd0, 16'd2);
    wait_idle("hdr_only_latch", 200);
    check("hdr_only_latch_w0", seen[0], 16'hAAAA);
    tready_rand = 1'b1;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 6; i++) h[i] = 16'($urandom);
      start_pkt(h, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                3'($urandom_range(0, 7)), 16'($urandom_range(0, 24)));
      wait_idle("rand", 2000);
    end

    // Reset in the middle of a packet.
    tready_rand = 1'b0;
    for (int i = 0; i < 6; i++) h[i] = 16'h7000 + 16'(i);
    start_pkt(h, 1'b1, 3'd0, 3'd1, 16'd512);
    n = 0;
    while (hs_count < 100 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    check("rst_beat100_reached", hs_count >= 100, 1);
    d0 = done_count;
    #1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_no_done", done_count - d0, 0);
    check("rst_overrun_clear", trigger_overrun, 0);
    // Header was cleared by reset; trigger without send_header sends zeros.
    start_pkt(h, 1'b0, 3'd2, 3'd2, 16'd4);
    wait_idle("post_rst", 200);
    check("post_rst_beats", hs_count, 10);
    check("post_rst_hdr0", seen[0], 16'h0000);
    check("post_rst_data0", seen[6], 16'h5234);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
